btn_press_encoder: RTL
======================

Name: btn_press_encoder

Overview:
Downstream consumer of the per-button debouncers in the whack-a-mole datapath. Takes the vector of debounced button levels and turns each press into a single event: button index, short/long flag and multi-press flag. Events go to the game FSM over a valid/ready handshake. Presses that cannot be serviced are counted in a saturating drop counter.

Parameters:
NUM_BTNS, 4, number of debounced button inputs (≥2); IDX_W = $clog2(NUM_BTNS) is derived as a localparam.
LONG_CNT, 16'd50000, hold duration in clk cycles that classifies a press as long (≥2); CNT_W = $clog2(LONG_CNT+1) is derived as a localparam.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
btn_db  in  NUM_BTNS  debounced button levels, 1 = pressed, already synchronous to clk
evt_ready  in  1  consumer accepts the event this cycle
drop_clr  in  1  synchronous clear of drop_cnt
evt_valid  out  1  event pending
evt_idx  out  IDX_W  index of the pressed button
evt_long  out  1  1 = long press, 0 = short press
evt_multi  out  1  more than one button rose in the capture cycle
drop_cnt  out  8  saturating count of ignored press cycles
busy  out  1  FSM not in IDLE

Behaviour:
- Reset is asynchronous and active-low. On rst_n=0:
  - FSM goes to IDLE; evt_valid, evt_idx, evt_long, evt_multi, drop_cnt and busy are all 0; the hold counter is 0.
  - prev_db resets to all ones, so a button held through reset produces no event until it is released and pressed again.
- Edge vector: rise = btn_db & ~prev_db, computed combinationally each cycle. prev_db <= btn_db every cycle.
- IDLE:
  - If rise≠0: capture evt_idx = lowest set bit index of rise; evt_multi = 1 when popcount(rise)>1; clear the counter; go to HOLD next cycle.
  - evt_long is cleared on capture.
- HOLD (each cycle, priority order):
  - (a) btn_db[evt_idx]==0 → EMIT with evt_long=0.
  - (b) else if cnt==LONG_CNT-1 → EMIT with evt_long=1.
  - (c) else cnt <= cnt+1.
  - Release beats the long threshold when both occur in the same cycle.
- EMIT:
  - evt_valid=1. evt_idx, evt_long and evt_multi are stable until the transfer.
  - Transfer happens on evt_valid && evt_ready. Next state is WAIT_REL if evt_long=1 and the button is still pressed, otherwise IDLE.
  - evt_valid is a registered output: it is high in exactly the EMIT cycles.
- WAIT_REL: stay until btn_db[evt_idx]==0, then go to IDLE. No event is produced on release of a long press.
- Latency:
  - Short press: edge at cycle t, release seen at cycle r → evt_valid at r+1.
  - Long press (button never released): evt_valid at t+LONG_CNT+1.
- Drops: drop_cnt increments by 1 in any cycle where rise≠0 and either:
  - FSM≠IDLE, or
  - FSM==IDLE and evt_multi is being set.
  - It saturates at 255. drop_clr=1 forces 0 and wins over a simultaneous increment.
- Other buttons' activity during HOLD/EMIT/WAIT_REL never alters the captured event.
- busy = (state≠IDLE), registered.

Decomposition:
- Shared package btn_pkg holds:
  - state encoding typedef btn_state_t {IDLE, HOLD, EMIT, WAIT_REL} (2 bits);
  - DROP_W=8;
  - DROP_MAX=8'hFF.
- One natural sub-module: btn_edge_detect.
  - Holds the prev_db register (reset to all ones) and produces rise[NUM_BTNS-1:0] plus rise_multi.
  - It is instantiated once. The FSM, counter, priority encoder and drop counter stay in the top.

Test Plan:
(NUM_BTNS=4, LONG_CNT=8 throughout.)
1. Short press: btn_db=4'b0100 at cycles 10–12, 0 from 13, evt_ready=1 → evt_valid high only at cycle 14 with evt_idx=2, evt_long=0, evt_multi=0; busy back to 0 at 15.
2. Long press: btn_db=4'b0010 from cycle 5 to 24, evt_ready=1 → evt_valid only at cycle 14 with evt_idx=1, evt_long=1; no event at release; busy=1 until 25, IDLE at 26.
3. Backpressure: short press of btn0 with evt_ready=0 for 5 cycles after evt_valid rises → evt_valid/evt_idx/evt_long stable for all 5 cycles; exactly one transfer when evt_ready=1; further presses of btn3 while pending → drop_cnt increments once per rising cycle.
4. Simultaneous: btn_db 4'b0000→4'b1010 in one cycle → evt_idx=1, evt_multi=1, drop_cnt 0→1; release only btn3 → FSM stays in HOLD.
5. Reset: btn_db=4'b0001 held while rst_n deasserts → no event. Release and re-press → event idx=0. Assert rst_n=0 mid-HOLD → outputs 0 immediately, without waiting for a clk edge.
6. Drop saturation: 300 ignored edge cycles → drop_cnt=255. drop_clr=1 in a cycle with an ignored edge → drop_cnt=0 next cycle.

Source files
------------

// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg : shared state encoding and drop-counter constants.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package btn_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    EMIT     = 2'd2,
    WAIT_REL = 2'd3
  } btn_state_t;

  localparam int              DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/btn_edge_detect.sv
// ---------------------------------------------------------------------------
// btn_edge_detect : rising-edge vector of the debounced buttons.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_edge_detect
  import btn_pkg::*;
#(
  parameter int NUM_BTNS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_BTNS-1:0] btn_db_i,
  output logic [NUM_BTNS-1:0] rise_o,
  output logic                rise_multi_o
);

  logic [NUM_BTNS-1:0] prev_db_q;

  // Reset to all ones so a button held through reset is not seen as a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_db_q <= '1;
    else         prev_db_q <= btn_db_i;
  end

  assign rise_o = btn_db_i & ~prev_db_q;

  // Clearing the lowest set bit leaves something only when two or more rose.
  assign rise_multi_o = |(rise_o & (rise_o - NUM_BTNS'(1)));

endmodule

`default_nettype wire

// File: rtl/btn_press_encoder.sv
// ---------------------------------------------------------------------------
// btn_press_encoder : turns debounced button presses into short/long events
// on a valid/ready handshake, counting unserviceable presses.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_press_encoder
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTNS = 4,
  parameter int unsigned LONG_CNT = 16'd50000,
  localparam int         IDX_W    = $clog2(NUM_BTNS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_BTNS-1:0] btn_db_i,
  input  logic                evt_ready_i,
  input  logic                drop_clr_i,
  output logic                evt_valid_o,
  output logic [IDX_W-1:0]    evt_idx_o,
  output logic                evt_long_o,
  output logic                evt_multi_o,
  output logic [DROP_W-1:0]   drop_cnt_o,
  output logic                busy_o
);

  localparam int              CNT_W     = $clog2(LONG_CNT + 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

  btn_state_t          state_q, state_d;
  logic [IDX_W-1:0]    evt_idx_q, evt_idx_d, first_idx;
  logic                evt_long_q, evt_long_d;
  logic                evt_multi_q, evt_multi_d;
  logic                evt_valid_q, evt_valid_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [NUM_BTNS-1:0] rise;
  logic                rise_multi;
  logic                held;

  btn_edge_detect #(
    .NUM_BTNS (NUM_BTNS)
  ) u_edge (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .btn_db_i     (btn_db_i),
    .rise_o       (rise),
    .rise_multi_o (rise_multi)
  );

  // Descending scan so the lowest rising index wins.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (rise[i]) first_idx = IDX_W'(i);
    end
  end

  assign held = btn_db_i[evt_idx_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      evt_idx_q   <= '0;
      evt_long_q  <= 1'b0;
      evt_multi_q <= 1'b0;
      evt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      evt_idx_q   <= evt_idx_d;
      evt_long_q  <= evt_long_d;
      evt_multi_q <= evt_multi_d;
      evt_valid_q <= evt_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (|rise) state_d = HOLD;
      HOLD:     if (!held || cnt_q == LONG_LAST) state_d = EMIT;
      EMIT:     if (evt_ready_i) state_d = (evt_long_q && held) ? WAIT_REL : IDLE;
      WAIT_REL: if (!held) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    evt_idx_d   = evt_idx_q;
    evt_long_d  = evt_long_q;
    evt_multi_d = evt_multi_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|rise) begin
          evt_idx_d   = first_idx;
          evt_multi_d = rise_multi;
          evt_long_d  = 1'b0;
          cnt_d       = '0;
        end
      end
      HOLD: begin
        // Release is checked first so it beats the long threshold.
        if (!held)                  evt_long_d = 1'b0;
        else if (cnt_q == LONG_LAST) evt_long_d = 1'b1;
        else                        cnt_d      = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase

    evt_valid_d = (state_d == EMIT);
    busy_d      = (state_d != IDLE);

    drop_d = drop_q;
    if (drop_clr_i)
      drop_d = '0;
    else if (|rise && (state_q != IDLE || rise_multi) && drop_q != DROP_MAX)
      drop_d = drop_q + DROP_W'(1);
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_idx_o   = evt_idx_q;
  assign evt_long_o  = evt_long_q;
  assign evt_multi_o = evt_multi_q;
  assign drop_cnt_o  = drop_q;
  assign busy_o      = busy_q;

endmodule

`default_nettype wire
